// File: rtl/mont_sq_sequencer.sv
// Montgomery squaring sequencer: drives one shared wide multiply-accumulate
// through T = x*x, m = T*N' mod R, U = m*N + T for a programmable iteration count.
module mont_sq_sequencer #(
  parameter int WIDTH      = 1024,
  parameter int MUL_WIDTH  = 1026,
  parameter int MUL_CYCLES = 4,
  parameter int ITER_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           modulus,
  input  logic [MUL_WIDTH-1:0]       n_prime,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MUL_WIDTH-1:0]       in_sq,
  input  logic [ITER_WIDTH-1:0]      in_iters,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MUL_WIDTH-1:0]       out_sq,
  output logic                       busy,
  output logic [MUL_WIDTH-1:0]       mul_x,
  output logic [MUL_WIDTH-1:0]       mul_y,
  output logic [2*MUL_WIDTH-1:0]     mul_accum,
  input  logic [2*MUL_WIDTH-1:0]     mul_p
);

  localparam int PH_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_RED_M,
    S_RED_U,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic [PH_W-1:0]          phase_q;
  logic [ITER_WIDTH-1:0]    iter_q;
  logic [2*MUL_WIDTH-1:0]   t_q;
  logic [2*MUL_WIDTH-1:0]   mul_accum_q;
  logic [MUL_WIDTH-1:0]     mul_x_q;
  logic [MUL_WIDTH-1:0]     mul_y_q;
  logic [MUL_WIDTH-1:0]     out_sq_q;
  logic                     out_valid_q;

  logic                     phase_end;
  logic [MUL_WIDTH-1:0]     p_lo;
  logic [MUL_WIDTH-1:0]     p_hi;

  // The product is only trusted on the edge closing a multicycle phase.
  assign phase_end = (phase_q == PH_W'(MUL_CYCLES - 1));
  assign p_lo      = mul_p[MUL_WIDTH-1:0];
  assign p_hi      = mul_p[2*MUL_WIDTH-1:MUL_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      iter_q      <= '0;
      t_q         <= '0;
      mul_accum_q <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      out_sq_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            iter_q  <= in_iters;
            phase_q <= '0;
            if (in_iters == '0) begin
              out_sq_q    <= in_sq;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              mul_x_q     <= in_sq;
              mul_y_q     <= in_sq;
              mul_accum_q <= '0;
              state_q     <= S_SQ;
            end
          end
        end

        S_SQ: begin
          if (phase_end) begin
            phase_q     <= '0;
            t_q         <= mul_p;
            mul_x_q     <= p_lo;
            mul_y_q     <= n_prime;
            mul_accum_q <= '0;
            state_q     <= S_RED_M;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

        S_RED_M: begin
          // Only m = T*N' mod R matters; the upper half of this product is dropped.
          if (phase_end) begin
            phase_q     <= '0;
            mul_x_q     <= p_lo;
            mul_y_q     <= MUL_WIDTH'(modulus);
            mul_accum_q <= t_q;
            state_q     <= S_RED_U;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

        S_RED_U: begin
          // m*N + T is a multiple of R, so the reduced square is the top half.
          if (phase_end) begin
            phase_q <= '0;
            iter_q  <= iter_q - ITER_WIDTH'(1);
            if (iter_q == ITER_WIDTH'(1)) begin
              out_sq_q    <= p_hi;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              mul_x_q     <= p_hi;
              mul_y_q     <= p_hi;
              mul_accum_q <= '0;
              state_q     <= S_SQ;
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_sq    = out_sq_q;
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign mul_accum = mul_accum_q;

endmodule

// File: tb/tb_mont_sq_sequencer.sv
// Bench for mont_sq_sequencer: models a multicycle multiplier that outputs garbage
// until its operands have been stable long enough, and checks results by modular math.
module tb_mont_sq_sequencer;

  localparam int WIDTH = 1024;
  localparam int MW    = 1026;
  localparam int M     = 4;
  localparam int IW    = 32;

  typedef logic [2*MW-1:0] big_t;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  modulus;
  logic [MW-1:0]     n_prime;
  logic              in_valid;
  logic              in_ready;
  logic [MW-1:0]     in_sq;
  logic [IW-1:0]     in_iters;
  logic              out_valid;
  logic              out_ready;
  logic [MW-1:0]     out_sq;
  logic              busy;
  logic [MW-1:0]     mul_x;
  logic [MW-1:0]     mul_y;
  logic [2*MW-1:0]   mul_accum;
  logic [2*MW-1:0]   mul_p;

  mont_sq_sequencer #(
    .WIDTH(WIDTH), .MUL_WIDTH(MW), .MUL_CYCLES(M), .ITER_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .modulus(modulus), .n_prime(n_prime),
    .in_valid(in_valid), .in_ready(in_ready), .in_sq(in_sq), .in_iters(in_iters),
    .out_valid(out_valid), .out_ready(out_ready), .out_sq(out_sq), .busy(busy),
    .mul_x(mul_x), .mul_y(mul_y), .mul_accum(mul_accum), .mul_p(mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Multiplier model: correct x*y+accum only once operands held M cycles.
  logic [4*MW-1:0] ops_now, ops_prev;
  int              stab = 0;
  big_t            ma, mb, mg;

  always @(negedge clk) begin
    ops_now = {mul_x, mul_y, mul_accum};
    if (ops_now !== ops_prev) stab = 1;
    else if (stab < 1000) stab = stab + 1;
    ops_prev = ops_now;
    ma = big_t'(mul_x);
    mb = big_t'(mul_y);
    if (stab >= M) begin
      mul_p = ma * mb + mul_accum;
    end else begin
      mg = '0;
      for (int i = 0; i < 65; i++) mg = {mg[2*MW-33:0], 32'($urandom)};
      mul_p = mg;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input big_t obs, input big_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic big_t rand_big();
    big_t r;
    r = '0;
    for (int i = 0; i < 65; i++) r = {r[2*MW-33:0], 32'($urandom)};
    return r;
  endfunction

  // -N^-1 mod 2^MW by Newton iteration (odd N is its own inverse mod 8).
  function automatic logic [MW-1:0] calc_np(input logic [MW-1:0] n);
    logic [MW-1:0] inv;
    inv = n;
    for (int i = 0; i < 11; i++) inv = inv * (MW'(2) - n * inv);
    return MW'(0) - inv;
  endfunction

  function automatic big_t modmul(input big_t a, input big_t b, input big_t n);
    return (a * b) % n;
  endfunction

  task automatic start(input logic [MW-1:0] sq, input logic [IW-1:0] iters);
    check("in_ready_before_start", big_t'(in_ready), 1);
    in_sq    = sq;
    in_iters = iters;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 5000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("out_valid_seen", big_t'(out_valid), 1);
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_after_handshake", big_t'(in_ready), 1);
  endtask

  int              lat;
  big_t            n_big, r_mod, x_big, lhs, rhs, hold;
  logic [MW-1:0]   rec_x, rec_y;
  big_t            rec_acc;

  initial begin
    rst_n     = 1'b0;
    modulus   = '0;
    n_prime   = '0;
    in_valid  = 1'b0;
    in_sq     = '0;
    in_iters  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", big_t'(in_ready), 1);
    check("rst_busy", big_t'(busy), 0);
    check("rst_out_valid", big_t'(out_valid), 0);
    check("rst_out_sq", big_t'(out_sq), 0);
    check("rst_mul_x", big_t'(mul_x), 0);
    check("rst_mul_y", big_t'(mul_y), 0);
    check("rst_mul_accum", mul_accum, 0);

    // N = 11, zero input stays zero through three squarings.
    n_big   = 11;
    modulus = WIDTH'(11);
    n_prime = calc_np(MW'(11));
    start(MW'(0), 3);
    check("zero_busy", big_t'(busy), 1);
    wait_out(lat);
    check("zero_latency", big_t'(lat), big_t'(3 * M * 3));
    check("zero_out_sq", big_t'(out_sq), 0);
    finish_out();

    // Montgomery one squares to itself modulo N.
    r_mod = (big_t'(1) << MW) % n_big;
    start(MW'(r_mod), 1);
    wait_out(lat);
    check("one_latency", big_t'(lat), big_t'(3 * M));
    check("one_congruence", big_t'(out_sq) % n_big, r_mod);
    check("one_bound", big_t'(big_t'(out_sq) < 2 * n_big), 1);
    finish_out();

    // Zero iterations: result is the input, multiplier operands untouched.
    rec_x   = mul_x;
    rec_y   = mul_y;
    rec_acc = mul_accum;
    start(MW'(12'h123), 0);
    check("iter0_out_valid", big_t'(out_valid), 1);
    check("iter0_out_sq", big_t'(out_sq), big_t'(12'h123));
    check("iter0_mul_x", big_t'(mul_x), big_t'(rec_x));
    check("iter0_mul_y", big_t'(mul_y), big_t'(rec_y));
    check("iter0_mul_accum", mul_accum, rec_acc);
    finish_out();

    // Backpressure with an ignored request pending during DONE.
    start(MW'(5), 1);
    wait_out(lat);
    check("bp_latency", big_t'(lat), big_t'(3 * M));
    hold = big_t'(out_sq);
    check("bp_congruence", modmul(hold % n_big, r_mod, n_big), big_t'(25 % 11));
    in_sq    = MW'(7);
    in_iters = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", big_t'(out_valid), 1);
      check("bp_out_sq", big_t'(out_sq), hold);
      check("bp_in_ready", big_t'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_valid", big_t'(out_valid), 0);
    check("bp_release_ready", big_t'(in_ready), 1);
    check("bp_release_busy", big_t'(busy), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accepted", big_t'(out_valid), 1);
    check("bp_next_out_sq", big_t'(out_sq), 7);
    finish_out();

    // Asynchronous reset while the reduction phase is in flight.
    start(MW'(3), 5);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", big_t'(busy), 1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", big_t'(busy), 0);
    check("mid_rst_out_valid", big_t'(out_valid), 0);
    check("mid_rst_out_sq", big_t'(out_sq), 0);
    check("mid_rst_mul_x", big_t'(mul_x), 0);
    check("mid_rst_mul_y", big_t'(mul_y), 0);
    check("mid_rst_mul_accum", mul_accum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_in_ready", big_t'(in_ready), 1);

    // Random odd 1024-bit moduli, four squarings each.
    for (int k = 0; k < 3; k++) begin
      n_big = rand_big() & ((big_t'(1) << WIDTH) - 1);
      n_big = n_big | big_t'(1) | (big_t'(1) << (WIDTH - 1));
      modulus = n_big[WIDTH-1:0];
      n_prime = calc_np(n_big[MW-1:0]);
      x_big = rand_big() % (2 * n_big);
      r_mod = (big_t'(1) << MW) % n_big;
      start(x_big[MW-1:0], 4);
      wait_out(lat);
      check("rand_latency", big_t'(lat), big_t'(3 * M * 4));
      check("rand_bound", big_t'(big_t'(out_sq) < 2 * n_big), 1);
      lhs = big_t'(out_sq) % n_big;
      for (int i = 0; i < 15; i++) lhs = modmul(lhs, r_mod, n_big);
      rhs = x_big % n_big;
      for (int i = 0; i < 4; i++) rhs = modmul(rhs, rhs, n_big);
      check("rand_congruence", lhs, rhs);
      finish_out();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
